// File: rtl/lvdc_timing_pkg.sv
// Shared definitions for the LVDC timing sequencer: state encoding, counter
// widths, default cadence values and a parameter range helper.
package lvdc_timing_pkg;

    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_STEP  = 2'd3
    } state_e;

    localparam int CLK_PHASE_W = 2;
    localparam int BIT_TIME_W  = 4;
    localparam int PHASE_W     = 2;

    localparam int DEF_CLK_PHASES      = 4;
    localparam int DEF_BITS_PER_PHASE  = 14;
    localparam int DEF_PHASES_PER_WORD = 3;

    // True when a modulus of 'value' can be counted in a 'width'-bit counter.
    function automatic logic fits(input int value, input int width);
        return (value >= 1) && (value <= (1 << width));
    endfunction

endpackage

// File: rtl/lvdc_edge_detect.sv
// Rising-edge detector for oscillator-derived signals: one clk-wide pulse per
// low-to-high transition of sig_i. The history register clears on reset.
module lvdc_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic rise_o
);

    logic sig_q;

    // Remember last cycle's level so a new high level can be recognised.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/lvdc_timing_seq.sv
// LVDC timing sequencer: turns osc_y rising edges into clock phase, bit time
// and word phase counts, and owns run/halt control so the machine only stops
// on a word boundary.
// Optional single-word stepping is built when LVDC_TIMING_STEP_EN is defined;
// without it the STEP state and the step_req/step_ack ports do not exist.
module lvdc_timing_seq
    import lvdc_timing_pkg::*;
#(
    parameter int CLK_PHASES      = DEF_CLK_PHASES,
    parameter int BITS_PER_PHASE  = DEF_BITS_PER_PHASE,
    parameter int PHASES_PER_WORD = DEF_PHASES_PER_WORD
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   osc_y,
    input  logic                   run_req,
    input  logic                   halt_req,
`ifdef LVDC_TIMING_STEP_EN
    input  logic                   step_req,
    output logic                   step_ack,
`endif
    output logic                   running,
    output logic                   halt_ack,
    output logic [CLK_PHASE_W-1:0] clk_phase,
    output logic [BIT_TIME_W-1:0]  bit_time,
    output logic [PHASE_W-1:0]     phase,
    output logic                   bit_strobe,
    output logic                   phase_strobe,
    output logic                   word_strobe
);

    if (!fits(CLK_PHASES, CLK_PHASE_W) || !fits(BITS_PER_PHASE, BIT_TIME_W) ||
        !fits(PHASES_PER_WORD, PHASE_W)) begin : g_cfg_check
        $error("lvdc_timing_seq: cadence parameters do not fit the counter widths");
    end

    localparam logic [CLK_PHASE_W-1:0] CP_LAST = CLK_PHASE_W'(CLK_PHASES - 1);
    localparam logic [BIT_TIME_W-1:0]  BT_LAST = BIT_TIME_W'(BITS_PER_PHASE - 1);
    localparam logic [PHASE_W-1:0]     PH_LAST = PHASE_W'(PHASES_PER_WORD - 1);

    state_e                 state_q, state_d;
    logic [CLK_PHASE_W-1:0] clk_phase_q, clk_phase_d;
    logic [BIT_TIME_W-1:0]  bit_time_q, bit_time_d;
    logic [PHASE_W-1:0]     phase_q, phase_d;
    logic                   bit_strobe_q, bit_strobe_d;
    logic                   phase_strobe_q, phase_strobe_d;
    logic                   word_strobe_q, word_strobe_d;
    logic                   running_q, running_d;
    logic                   halt_ack_q, halt_ack_d;
    logic                   tick;
    logic                   boundary;
`ifdef LVDC_TIMING_STEP_EN
    logic                   step_ack_q, step_ack_d;
    logic                   step_armed_q, step_armed_d;
`endif

    lvdc_edge_detect u_osc_edge (
        .clk    (clk),
        .rst    (rst),
        .sig_i  (osc_y),
        .rise_o (tick)
    );

    // Next counters, strobes and control state from the current tick and requests.
    always_comb begin
        clk_phase_d    = clk_phase_q;
        bit_time_d     = bit_time_q;
        phase_d        = phase_q;
        bit_strobe_d   = 1'b0;
        phase_strobe_d = 1'b0;
        word_strobe_d  = 1'b0;
        boundary       = 1'b0;

        if (tick && running_q) begin
            if (clk_phase_q == CP_LAST) begin
                clk_phase_d  = '0;
                bit_strobe_d = 1'b1;
                if (bit_time_q == BT_LAST) begin
                    bit_time_d     = '0;
                    phase_strobe_d = 1'b1;
                    if (phase_q == PH_LAST) begin
                        phase_d       = '0;
                        word_strobe_d = 1'b1;
                        boundary      = 1'b1;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end else begin
                    bit_time_d = bit_time_q + 1'b1;
                end
            end else begin
                clk_phase_d = clk_phase_q + 1'b1;
            end
        end

        state_d = state_q;
        case (state_q)
            ST_HALT: begin
                if (!halt_req) begin
                    if (run_req) begin
                        state_d = ST_RUN;
                    end
`ifdef LVDC_TIMING_STEP_EN
                    else if (step_req && step_armed_q) begin
                        state_d = ST_STEP;
                    end
`endif
                end
            end
            ST_RUN: begin
                if (halt_req) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (boundary) begin
                    state_d = ST_HALT;
                end else if (!halt_req) begin
                    state_d = ST_RUN;
                end
            end
`ifdef LVDC_TIMING_STEP_EN
            ST_STEP: begin
                if (boundary) begin
                    state_d = ST_HALT;
                end
            end
`endif
            default: state_d = ST_HALT;
        endcase

        // A halted machine always rests at the start of a word.
        if (state_d == ST_HALT) begin
            clk_phase_d = '0;
            bit_time_d  = '0;
            phase_d     = '0;
        end

        running_d  = (state_d != ST_HALT);
        halt_ack_d = (state_d == ST_HALT);

`ifdef LVDC_TIMING_STEP_EN
        step_ack_d   = (state_q == ST_STEP) && boundary;
        step_armed_d = step_armed_q;
        if (!step_req) begin
            step_armed_d = 1'b1;
        end else if ((state_q == ST_HALT) && (state_d == ST_STEP)) begin
            step_armed_d = 1'b0;
        end
`endif
    end

    // Register the FSM, counters and every output together.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= ST_HALT;
            clk_phase_q    <= '0;
            bit_time_q     <= '0;
            phase_q        <= '0;
            bit_strobe_q   <= 1'b0;
            phase_strobe_q <= 1'b0;
            word_strobe_q  <= 1'b0;
            running_q      <= 1'b0;
            halt_ack_q     <= 1'b1;
`ifdef LVDC_TIMING_STEP_EN
            step_ack_q     <= 1'b0;
            step_armed_q   <= 1'b1;
`endif
        end else begin
            state_q        <= state_d;
            clk_phase_q    <= clk_phase_d;
            bit_time_q     <= bit_time_d;
            phase_q        <= phase_d;
            bit_strobe_q   <= bit_strobe_d;
            phase_strobe_q <= phase_strobe_d;
            word_strobe_q  <= word_strobe_d;
            running_q      <= running_d;
            halt_ack_q     <= halt_ack_d;
`ifdef LVDC_TIMING_STEP_EN
            step_ack_q     <= step_ack_d;
            step_armed_q   <= step_armed_d;
`endif
        end
    end

    assign running      = running_q;
    assign halt_ack     = halt_ack_q;
    assign clk_phase    = clk_phase_q;
    assign bit_time     = bit_time_q;
    assign phase        = phase_q;
    assign bit_strobe   = bit_strobe_q;
    assign phase_strobe = phase_strobe_q;
    assign word_strobe  = word_strobe_q;
`ifdef LVDC_TIMING_STEP_EN
    assign step_ack     = step_ack_q;
`endif

endmodule

// File: tb/tb_lvdc_timing_seq.sv
// Testbench for lvdc_timing_seq. A behavioural model counts ticks accepted
// since the machine left HALT and derives counters and strobes arithmetically.
// Step scenarios are included when LVDC_TIMING_STEP_EN is defined.
`timescale 1ns/1ps
module tb_lvdc_timing_seq;

    localparam int CP  = 4;
    localparam int BP  = 14;
    localparam int PW  = 3;
    localparam int TPW = CP * BP * PW;
    localparam logic [13:0] RESET_VEC = 14'h1000;

    logic       clk      = 1'b0;
    logic       rst      = 1'b0;
    logic       osc_y    = 1'b0;
    logic       run_req  = 1'b0;
    logic       halt_req = 1'b0;
    logic       running, halt_ack;
    logic [1:0] clk_phase;
    logic [3:0] bit_time;
    logic [1:0] phase;
    logic       bit_strobe, phase_strobe, word_strobe;
    logic       stepIn;
    logic       dutAck;
    logic [13:0] dutVec;

    int checks = 0;
    int fails  = 0;

`ifdef LVDC_TIMING_STEP_EN
    logic step_req = 1'b0;
    logic step_ack;
    assign stepIn = step_req;
    assign dutAck = step_ack;
`else
    assign stepIn = 1'b0;
    assign dutAck = 1'b0;
`endif

    lvdc_timing_seq dut (
        .clk          (clk),
        .rst          (rst),
        .osc_y        (osc_y),
        .run_req      (run_req),
        .halt_req     (halt_req),
`ifdef LVDC_TIMING_STEP_EN
        .step_req     (step_req),
        .step_ack     (step_ack),
`endif
        .running      (running),
        .halt_ack     (halt_ack),
        .clk_phase    (clk_phase),
        .bit_time     (bit_time),
        .phase        (phase),
        .bit_strobe   (bit_strobe),
        .phase_strobe (phase_strobe),
        .word_strobe  (word_strobe)
    );

    assign dutVec = {running, halt_ack, clk_phase, bit_time, phase,
                     bit_strobe, phase_strobe, word_strobe, dutAck};

    always #5 clk = ~clk;

    // osc_y toggles every 10 clk, shortly after the clock edge.
    initial begin : oscGen
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            cnt++;
            if (cnt == 10) begin
                cnt   = 0;
                osc_y = ~osc_y;
            end
        end
    end

    // Reference model: ticks counted since leaving HALT; counters are digits of that count.
    typedef enum {M_IDLE, M_GO, M_STOPPING, M_ONEWORD} mode_t;
    mode_t  mMode    = M_IDLE;
    longint mTicks   = 0;
    bit     mOscPrev = 1'b0;
    bit     mArmed   = 1'b1;
    bit     mBit = 1'b0, mPh = 1'b0, mWd = 1'b0, mAck = 1'b0;

    initial begin : model
        bit tickNow, counted, atWord;
        forever begin
            @(posedge clk);
            tickNow = osc_y && !mOscPrev;
            if (!rst) begin
                mMode = M_IDLE; mTicks = 0; mOscPrev = 1'b0; mArmed = 1'b1;
                mBit = 1'b0; mPh = 1'b0; mWd = 1'b0; mAck = 1'b0;
            end else begin
                mOscPrev = osc_y;
                counted  = (mMode != M_IDLE) && tickNow;
                if (counted) mTicks++;
                atWord = counted && (mTicks % TPW == 0);
                mBit   = counted && (mTicks % CP == 0);
                mPh    = counted && (mTicks % (CP * BP) == 0);
                mWd    = atWord;
                mAck   = (mMode == M_ONEWORD) && atWord;
                case (mMode)
                    M_IDLE: if (!halt_req) begin
                        if (run_req) mMode = M_GO;
                        else if (stepIn && mArmed) begin
                            mMode  = M_ONEWORD;
                            mArmed = 1'b0;
                        end
                    end
                    M_GO:       if (halt_req) mMode = M_STOPPING;
                    M_STOPPING: if (atWord) mMode = M_IDLE; else if (!halt_req) mMode = M_GO;
                    M_ONEWORD:  if (atWord) mMode = M_IDLE;
                    default:    mMode = M_IDLE;
                endcase
                if (!stepIn) mArmed = 1'b1;
                if (mMode == M_IDLE) mTicks = 0;
            end
        end
    end

    function automatic logic [13:0] expVec();
        return {mMode != M_IDLE, mMode == M_IDLE,
                2'(mTicks % CP), 4'((mTicks / CP) % BP), 2'((mTicks / (CP * BP)) % PW),
                mBit, mPh, mWd, mAck};
    endfunction

    task automatic test_reset();
        rst = 1'b0; run_req = 1'b0; halt_req = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (dutVec !== RESET_VEC) begin
            fails++;
            $display("[TB] FAIL reset_hold got=%h want=%h", dutVec, RESET_VEC);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (dutVec !== RESET_VEC) begin
            fails++;
            $display("[TB] FAIL reset_release got=%h want=%h", dutVec, RESET_VEC);
        end
    endtask

    task automatic test_run();
        int lastBit = -1, lastPh = -1, lastWd = -1, nBit = 0;
        repeat ($urandom_range(1, 15)) @(negedge clk);
        run_req = 1'b1; halt_req = 1'b0;
        for (int c = 0; c < 7000; c++) begin
            @(negedge clk);
            checks++;
            if (dutVec !== expVec()) begin
                fails++;
                $display("[TB] FAIL run_model cyc=%0d got=%h want=%h", c, dutVec, expVec());
            end
            if (bit_strobe === 1'b1) begin
                if (lastBit >= 0) begin
                    checks++;
                    if (c - lastBit != 80) begin
                        fails++;
                        $display("[TB] FAIL run_bit_period got=%0d want=80", c - lastBit);
                    end
                end
                lastBit = c; nBit++;
            end
            if (phase_strobe === 1'b1) begin
                if (lastPh >= 0) begin
                    checks++;
                    if (c - lastPh != 1120) begin
                        fails++;
                        $display("[TB] FAIL run_phase_period got=%0d want=1120", c - lastPh);
                    end
                end
                lastPh = c;
            end
            if (word_strobe === 1'b1) begin
                if (lastWd >= 0) begin
                    checks++;
                    if (c - lastWd != 3360) begin
                        fails++;
                        $display("[TB] FAIL run_word_period got=%0d want=3360", c - lastWd);
                    end
                end
                lastWd = c;
            end
        end
        checks++;
        if (nBit < 86 || nBit > 88) begin
            fails++;
            $display("[TB] FAIL run_bit_count got=%0d want=86..88", nBit);
        end
    endtask

    task automatic test_halt_pulse();
        int  lastBit = -1, c = 0;
        bit  found = 1'b0, sawHalt = 1'b0;
        run_req = 1'b1; halt_req = 1'b0;
        while (!found && c < 4000) begin
            @(negedge clk);
            c++;
            found = (phase == 2'd0) && (bit_time == 4'd2);
        end
        checks++;
        if (!found) begin
            fails++;
            $display("[TB] FAIL pulse_wait got=timeout want=phase0_bit2");
        end
        for (int k = 0; k < 2500; k++) begin
            halt_req = (k < 100);
            @(negedge clk);
            checks++;
            if (dutVec !== expVec()) begin
                fails++;
                $display("[TB] FAIL pulse_model cyc=%0d got=%h want=%h", k, dutVec, expVec());
            end
            if (halt_ack === 1'b1) sawHalt = 1'b1;
            if (bit_strobe === 1'b1) begin
                if (lastBit >= 0) begin
                    checks++;
                    if (k - lastBit != 80) begin
                        fails++;
                        $display("[TB] FAIL pulse_bit_period got=%0d want=80", k - lastBit);
                    end
                end
                lastBit = k;
            end
        end
        checks++;
        if (sawHalt) begin
            fails++;
            $display("[TB] FAIL pulse_no_stop got=halted want=running");
        end
    endtask

    task automatic test_halt_at();
        int  c = 0, nWord = 0;
        bit  found = 1'b0, done = 1'b0;
        run_req = 1'b1; halt_req = 1'b0;
        while (!found && c < 5000) begin
            @(negedge clk);
            c++;
            found = (phase == 2'd1) && (bit_time == 4'd5);
        end
        checks++;
        if (!found) begin
            fails++;
            $display("[TB] FAIL halt_wait got=timeout want=phase1_bit5");
        end
        run_req = 1'b0; halt_req = 1'b1;
        c = 0;
        while (!done && c < 4000) begin
            @(negedge clk);
            c++;
            checks++;
            if (dutVec !== expVec()) begin
                fails++;
                $display("[TB] FAIL halt_model cyc=%0d got=%h want=%h", c, dutVec, expVec());
            end
            if (word_strobe === 1'b1) nWord++;
            done = (halt_ack === 1'b1);
        end
        checks++;
        if (!done) begin
            fails++;
            $display("[TB] FAIL halt_timeout got=running want=halt_ack");
        end
        checks++;
        if ({running, clk_phase, bit_time, phase} !== 9'd0) begin
            fails++;
            $display("[TB] FAIL halt_counters got=%b want=0", {running, clk_phase, bit_time, phase});
        end
        checks++;
        if (nWord != 1) begin
            fails++;
            $display("[TB] FAIL halt_word_once got=%0d want=1", nWord);
        end
        halt_req = 1'b0;
    endtask

    task automatic test_both_high();
        int busy = 0;
        run_req = 1'b1; halt_req = 1'b1;
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            checks++;
            if (dutVec !== expVec()) begin
                fails++;
                $display("[TB] FAIL both_model cyc=%0d got=%h want=%h", k, dutVec, expVec());
            end
            if (running || bit_strobe || phase_strobe || word_strobe || !halt_ack) busy++;
        end
        checks++;
        if (busy != 0) begin
            fails++;
            $display("[TB] FAIL both_stays_halt got=%0d want=0", busy);
        end
        run_req = 1'b0; halt_req = 1'b0;
    endtask

    task automatic test_mid_reset();
        int c = 0;
        bit found = 1'b0;
        run_req = 1'b1; halt_req = 1'b0;
        while (!found && c < 4000) begin
            @(negedge clk);
            c++;
            found = (phase == 2'd2) && (bit_time == 4'd9);
        end
        checks++;
        if (!found) begin
            fails++;
            $display("[TB] FAIL midrst_wait got=timeout want=phase2_bit9");
        end
        rst = 1'b0; run_req = 1'b0;
        @(negedge clk);
        checks++;
        if (dutVec !== RESET_VEC) begin
            fails++;
            $display("[TB] FAIL midrst_values got=%h want=%h", dutVec, RESET_VEC);
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (dutVec !== expVec()) begin
            fails++;
            $display("[TB] FAIL midrst_after got=%h want=%h", dutVec, expVec());
        end
    endtask

`ifdef LVDC_TIMING_STEP_EN
    task automatic test_step();
        int nAck = 0, nWord = 0, runCyc = 0;
        run_req = 1'b0; halt_req = 1'b0; step_req = 1'b1;
        for (int k = 0; k < 10000; k++) begin
            @(negedge clk);
            checks++;
            if (dutVec !== expVec()) begin
                fails++;
                $display("[TB] FAIL step_model cyc=%0d got=%h want=%h", k, dutVec, expVec());
            end
            if (step_ack === 1'b1) nAck++;
            if (word_strobe === 1'b1) nWord++;
            if (running === 1'b1) runCyc++;
        end
        checks++;
        if (nAck != 1) begin
            fails++;
            $display("[TB] FAIL step_ack_once got=%0d want=1", nAck);
        end
        checks++;
        if (nWord != 1) begin
            fails++;
            $display("[TB] FAIL step_one_word got=%0d want=1", nWord);
        end
        checks++;
        if (runCyc < 3341 || runCyc > 3360) begin
            fails++;
            $display("[TB] FAIL step_length got=%0d want=3341..3360", runCyc);
        end
        checks++;
        if (halt_ack !== 1'b1) begin
            fails++;
            $display("[TB] FAIL step_end_halt got=%b want=1", halt_ack);
        end
        step_req = 1'b0;
        @(negedge clk);
    endtask
`endif

    task automatic test_random();
        for (int k = 0; k < 8000; k++) begin
            if ($urandom_range(0, 199) == 0) run_req  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 299) == 0) halt_req = 1'($urandom_range(0, 1));
`ifdef LVDC_TIMING_STEP_EN
            if ($urandom_range(0, 249) == 0) step_req = 1'($urandom_range(0, 1));
`endif
            @(negedge clk);
            checks++;
            if (dutVec !== expVec()) begin
                fails++;
                $display("[TB] FAIL random_model cyc=%0d got=%h want=%h", k, dutVec, expVec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_run();
        test_halt_pulse();
        test_halt_at();
        test_both_high();
        test_mid_reset();
`ifdef LVDC_TIMING_STEP_EN
        test_step();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
